// File: rtl/md_sched_pkg.sv
// Shared command codes, FSM state type and op-class helpers for the
// multiply/divide sequencing controller.
package md_sched_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Commands that occupy the unit for a multi-cycle latency window.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply / divide of latched operands.
// res_ok is low for a divide by zero so the caller can keep HI/LO unchanged.
module md_arith
    import md_sched_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        res_ok
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic               sdiv;
    logic        [31:0] ua;
    logic        [31:0] ub;
    logic        [31:0] ub_safe;
    logic        [31:0] uq;
    logic        [31:0] ur;

    assign sa    = $signed({{32{a[31]}}, a});
    assign sb    = $signed({{32{b[31]}}, b});
    assign sprod = sa * sb;
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows.
    assign sdiv    = (op == MD_DIV);
    assign ua      = (sdiv && a[31]) ? -a : a;
    assign ub      = (sdiv && b[31]) ? -b : b;
    assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    assign uq      = ua / ub_safe;
    assign ur      = ua % ub_safe;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        res_ok = 1'b1;
        case (op)
            MD_MULT:  {hi_res, lo_res} = sprod;
            MD_MULTU: {hi_res, lo_res} = uprod;
            MD_DIV, MD_DIVU: begin
                lo_res = (sdiv && (a[31] ^ b[31])) ? -uq : uq;
                hi_res = (sdiv && a[31]) ? -ur : ur;
                res_ok = (b != 32'd0);
            end
            default: res_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency with a busy
// counter and raises the D-stage stall for instructions that touch HI/LO.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_use_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_err
);

    md_state_e   state;
    logic [3:0]  cnt_p0;
    logic [2:0]  op_p0;
    logic [31:0] a_p0;
    logic [31:0] b_p0;
    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        res_ok;

    md_arith u_arith (
        .op     (op_p0),
        .a      (a_p0),
        .b      (b_p0),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .res_ok (res_ok)
    );

    // Stall covers the start cycle too, before busy has risen.
    assign md_stall = D_use_md & (busy | (E_start & is_long_op(E_op)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt_p0 <= 4'd0;
            busy   <= 1'b0;
            md_err <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            op_p0  <= MD_MULT;
            a_p0   <= 32'd0;
            b_p0   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_start) begin
                        if (is_long_op(E_op)) begin
                            op_p0  <= E_op;
                            a_p0   <= E_A;
                            b_p0   <= E_B;
                            cnt_p0 <= is_mult_op(E_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            state  <= BUSY;
                            busy   <= 1'b1;
                        end else if (E_op == MD_MTHI) begin
                            HI <= E_A;
                        end else if (E_op == MD_MTLO) begin
                            LO <= E_A;
                        end else begin
                            md_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (E_start) begin
                        md_err <= 1'b1;
                    end
                    if (cnt_p0 == 4'd1) begin
                        if (res_ok) begin
                            HI <= hi_res;
                            LO <= lo_res;
                        end
                        cnt_p0 <= 4'd0;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        cnt_p0 <= cnt_p0 - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Randomized and directed bench for md_sched against a cycle-level reference
// model that tracks remaining latency and a pending HI/LO result.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_start = 1'b0;
    logic [2:0]  E_op = 3'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        D_use_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_rem = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    logic        m_pok = 1'b0;
    logic        m_err = 1'b0;

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_op     (E_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_use_md (D_use_md),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO),
        .md_err   (md_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Result computed from the arithmetic definitions with 64-bit integers.
    task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_pok = 1'b1;
        case (op)
            MD_MULT:  begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; end
            MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; m_phi = up[63:32]; m_plo = up[31:0]; end
            MD_DIV: begin
                if (b == 32'd0) m_pok = 1'b0;
                else begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
            end
            default: begin
                if (b == 32'd0) m_pok = 1'b0;
                else begin m_plo = a / b; m_phi = a % b; end
            end
        endcase
    endtask

    task automatic model_edge(input logic rst_i, input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        if (rst_i) begin
            m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
        end else if (m_rem > 0) begin
            if (st) m_err = 1'b1;
            m_rem--;
            if (m_rem == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            if (op <= 3'd3) begin
                model_result(op, a, b);
                m_rem = (op <= 3'd1) ? MULT_N : DIV_N;
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
            else m_err = 1'b1;
        end
    endtask

    task automatic step(input logic rst_i, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic du);
        logic exp_stall;
        @(negedge clk);
        reset = rst_i; E_start = st; E_op = op; E_A = a; E_B = b; D_use_md = du;
        exp_stall = du && ((m_rem > 0) || (st && op <= 3'd3));
        #1;
        check("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
        @(posedge clk);
        model_edge(rst_i, st, op, a, b);
        #1;
        check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
        check("md_err", {31'd0, md_err}, {31'd0, m_err});
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, MD_MULT, 32'd0, 32'd0, du);
    endtask

    task automatic wait_idle(input logic du);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            idle(1, du);
            k++;
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic st, rs, du;
        logic [2:0] op;

        step(1'b1, 1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        // MULT -2 * 3 with a stalled D instruction
        step(1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(MULT_N - 1, 1'b1);
        check("mult_busy_last", {31'd0, busy}, 32'd1);
        check("mult_hi_early", HI, 32'd0);
        idle(1, 1'b1);
        check("mult_busy_fall", {31'd0, busy}, 32'd0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        idle(1, 1'b1);
        check("stall_after", {31'd0, md_stall}, 32'd0);

        step(1'b0, 1'b1, MD_DIVU, 32'd17, 32'd5, 1'b0);
        wait_idle(1'b0);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd2);

        step(1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle(1'b0);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(1'b0);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        step(1'b0, 1'b1, MD_MTHI, 32'h11, 32'd0, 1'b1);
        step(1'b0, 1'b1, MD_MTLO, 32'h22, 32'd0, 1'b1);
        step(1'b0, 1'b1, MD_DIV, 32'd5, 32'd0, 1'b0);
        wait_idle(1'b0);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        step(1'b0, 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle(1'b0);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        // Illegal start while busy; original result must still land
        step(1'b0, 1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, MD_DIVU, 32'd1, 32'd1, 1'b0);
        check("err_busy", {31'd0, md_err}, 32'd1);
        wait_idle(1'b0);
        check("err_lo", LO, 32'd14);
        check("err_hi", HI, 32'd2);

        // Reset with counter at 3 aborts with no late write
        step(1'b0, 1'b1, MD_DIVU, 32'd9, 32'd2, 1'b0);
        idle(DIV_N - 3, 1'b0);
        step(1'b1, 1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {31'd0, md_err}, 32'd0);
        idle(12, 1'b0);
        check("abort_lo", LO, 32'd0);
        check("abort_hi", HI, 32'd0);

        step(1'b0, 1'b1, 3'd7, 32'd5, 32'd5, 1'b0);
        check("reserved_err", {31'd0, md_err}, 32'd1);

        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            du = $urandom_range(0, 1) == 1;
            op = 3'($urandom_range(0, 7));
            if (m_rem > 0) st = ($urandom_range(0, 29) == 0);
            else st = ($urandom_range(0, 2) == 0);
            if (op >= 3'd6 && $urandom_range(0, 3) != 0) op = MD_DIV;
            step(rs, st, op, pick_operand(), pick_operand(), du);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
